// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: pc handshake, instruction-memory read port and decoder valid/ready.
// The queue takes the slave view; the surrounding pc/memory/decoder logic takes the master view.
interface ifetch_queue_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  // pc side
  logic [ADDR_W-1:0] fetch_adrx;
  logic              flush;
  logic              hold;
  // instruction memory side
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_adrx;
  logic [DATA_W-1:0] imem_data;
  // decoder side
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_adrx;
  logic              instr_valid;
  logic              instr_ready;
  logic              align_err;

  modport slave (
    input  fetch_adrx, flush, imem_data, instr_ready,
    output hold, imem_rd, imem_adrx, instr, instr_adrx, instr_valid, align_err
  );

  modport master (
    output fetch_adrx, flush, imem_data, instr_ready,
    input  hold, imem_rd, imem_adrx, instr, instr_adrx, instr_valid, align_err
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one synchronous imem read per cycle at the pc address and
// buffers {word, address} pairs in a small FIFO for the decoder; a branch flush drops everything.
module ifetch_queue #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           rst,
  ifetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] adrx;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              inflight;
  logic [ADDR_W-1:0] addr_q;
  logic              align_q;

  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              push;
  logic              pop;

  // Words already queued plus the one still coming back from memory both claim a slot,
  // so a full reservation stalls the pc before the FIFO can overflow.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign bus.hold  = occupancy >= (CNT_W + 1)'(DEPTH);

  assign issue         = ~bus.hold & ~bus.flush & rst;
  assign bus.imem_rd   = issue;
  assign bus.imem_adrx = bus.fetch_adrx;

  // A response landing in the flush cycle belongs to the wrong path and is dropped.
  assign push = inflight & ~bus.flush;
  assign pop  = bus.instr_valid & bus.instr_ready;

  assign bus.instr_valid            = count != '0;
  assign {bus.instr, bus.instr_adrx} = mem[rd_ptr];
  assign bus.align_err              = align_q;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: FIFO storage has no reset; count gates instr_valid, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: bus.imem_data, adrx: addr_q};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      addr_q   <= '0;
      align_q  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        addr_q <= bus.fetch_adrx;
      end
      if (issue && (bus.fetch_adrx[1:0] != 2'b00)) begin
        align_q <= 1'b1;
      end
      if (bus.flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_ifetch_queue;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int NVEC   = 17;
  localparam int NRAND  = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ifetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h100 + 32'(a);
  endfunction

  // Instruction memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_data <= mem_word(bus.imem_adrx);
  end

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              ready;
    logic              valid;
    logic [ADDR_W-1:0] adrx;
    logic              hold;
    logic              rd;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] adrx;
    logic [DATA_W-1:0] data;
  } word_t;

  vec_t tbl [NVEC];

  // Reference model state
  word_t             q[$];
  bit                m_inf;
  logic [ADDR_W-1:0] m_inf_adrx;
  bit                m_align;
  logic [ADDR_W-1:0] pc;

  initial begin
    // pc, flush, ready | valid, adrx, hold, rd
    // Backpressure from reset: fill to DEPTH, single pops, then a flush with 2 queued + 1 in flight.
    tbl[0]  = '{9'h000, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1};
    tbl[1]  = '{9'h004, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1};
    tbl[2]  = '{9'h008, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1};
    tbl[3]  = '{9'h00C, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1};
    tbl[4]  = '{9'h010, 1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 1'b0};
    tbl[5]  = '{9'h010, 1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 1'b0};
    tbl[6]  = '{9'h010, 1'b0, 1'b1, 1'b1, 9'h000, 1'b1, 1'b0};
    tbl[7]  = '{9'h010, 1'b0, 1'b0, 1'b1, 9'h004, 1'b0, 1'b1};
    tbl[8]  = '{9'h014, 1'b0, 1'b0, 1'b1, 9'h004, 1'b1, 1'b0};
    tbl[9]  = '{9'h014, 1'b0, 1'b1, 1'b1, 9'h004, 1'b1, 1'b0};
    tbl[10] = '{9'h014, 1'b0, 1'b1, 1'b1, 9'h008, 1'b0, 1'b1};
    tbl[11] = '{9'h018, 1'b0, 1'b1, 1'b1, 9'h00C, 1'b0, 1'b1};
    tbl[12] = '{9'h01C, 1'b0, 1'b1, 1'b1, 9'h010, 1'b0, 1'b1};
    tbl[13] = '{9'h020, 1'b1, 1'b1, 1'b1, 9'h014, 1'b0, 1'b0};
    tbl[14] = '{9'h040, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1};
    tbl[15] = '{9'h044, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1};
    tbl[16] = '{9'h048, 1'b0, 1'b1, 1'b1, 9'h040, 1'b0, 1'b1};

    rst             = 1'b0;
    bus.fetch_adrx  = '0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.imem_data   = '0;

    repeat (2) @(negedge clk);
    check("reset_valid", 32'(bus.instr_valid), 32'(0));
    check("reset_hold",  32'(bus.hold),        32'(0));
    check("reset_rd",    32'(bus.imem_rd),     32'(0));
    check("reset_align", 32'(bus.align_err),   32'(0));

    // ---------------- table-driven vectors ----------------
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) @(negedge clk);
      bus.fetch_adrx  = tbl[i].pc;
      bus.flush       = tbl[i].flush;
      bus.instr_ready = tbl[i].ready;
      #1;
      check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
      check($sformatf("vec%0d_hold", i),  32'(bus.hold),        32'(tbl[i].hold));
      check($sformatf("vec%0d_rd", i),    32'(bus.imem_rd),     32'(tbl[i].rd));
      check($sformatf("vec%0d_imem_adrx", i), 32'(bus.imem_adrx), 32'(tbl[i].pc));
      if (tbl[i].valid) begin
        check($sformatf("vec%0d_adrx", i),  32'(bus.instr_adrx), 32'(tbl[i].adrx));
        check($sformatf("vec%0d_instr", i), bus.instr, mem_word(tbl[i].adrx));
      end
    end

    // ---------------- misaligned fetch: sticky error, fetch still performed ----------------
    @(negedge clk);
    bus.fetch_adrx = 9'h006; bus.flush = 1'b0; bus.instr_ready = 1'b1;
    #1;
    check("mis_align_before", 32'(bus.align_err), 32'(0));
    check("mis_rd",           32'(bus.imem_rd),   32'(1));
    @(negedge clk);
    bus.fetch_adrx = 9'h00A;
    #1;
    check("mis_align_set", 32'(bus.align_err),  32'(1));
    check("mis_adrx_048",  32'(bus.instr_adrx), 32'(9'h048));
    @(negedge clk);
    bus.fetch_adrx = 9'h00E;
    #1;
    check("mis_adrx_006",  32'(bus.instr_adrx), 32'(9'h006));
    check("mis_instr_006", bus.instr,           mem_word(9'h006));
    check("mis_align_hold", 32'(bus.align_err), 32'(1));

    // ---------------- asynchronous reset with 3 queued ----------------
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.fetch_adrx = 9'(9'h012 + 9'(4 * k));
      #1;
    end
    check("pre_rst_valid", 32'(bus.instr_valid), 32'(1));
    check("pre_rst_hold",  32'(bus.hold),        32'(1));
    #1;
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(bus.instr_valid), 32'(0));
    check("rst_hold",  32'(bus.hold),        32'(0));
    check("rst_rd",    32'(bus.imem_rd),     32'(0));
    check("rst_align", 32'(bus.align_err),   32'(0));

    // ---------------- randomized traffic vs reference model ----------------
    q.delete();
    m_inf      = 1'b0;
    m_inf_adrx = '0;
    m_align    = 1'b0;
    pc         = 9'h100;
    for (int i = 0; i < NRAND; i++) begin
      bit flush_b, ready_b, e_valid, e_hold, e_rd;
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      flush_b = ($urandom_range(0, 19) == 0);
      ready_b = ($urandom_range(0, 9) < 6);
      bus.fetch_adrx  = pc;
      bus.flush       = flush_b;
      bus.instr_ready = ready_b;
      #1;
      e_valid = (q.size() != 0);
      e_hold  = ((q.size() + int'(m_inf)) >= DEPTH);
      e_rd    = !e_hold && !flush_b;
      check("rnd_valid", 32'(bus.instr_valid), 32'(e_valid));
      check("rnd_hold",  32'(bus.hold),        32'(e_hold));
      check("rnd_rd",    32'(bus.imem_rd),     32'(e_rd));
      check("rnd_align", 32'(bus.align_err),   32'(m_align));
      if (e_valid) begin
        check("rnd_adrx",  32'(bus.instr_adrx), 32'(q[0].adrx));
        check("rnd_instr", bus.instr,           q[0].data);
      end
      @(posedge clk);
      if (flush_b) begin
        q.delete();
        m_inf = 1'b0;
        pc    = 9'($urandom_range(0, 127) * 4);
      end else begin
        if (e_valid && ready_b) void'(q.pop_front());
        if (m_inf) q.push_back('{adrx: m_inf_adrx, data: mem_word(m_inf_adrx)});
        m_inf      = e_rd;
        m_inf_adrx = pc;
        if (e_rd && (pc[1:0] != 2'b00)) m_align = 1'b1;
        if (e_rd) begin
          pc = pc + 9'd4;
          if (i > 2000 && $urandom_range(0, 49) == 0) pc = pc + 9'd2;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
